// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the round-robin tri-state bus arbiter.
// State encodings are fixed so that debug probes can decode them directly.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin winner select: first set request above ptr, wrapping.
// The request vector is doubled so the wrap becomes a plain masked priority encode.
module rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [ID_W-1:0]    win_id
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] mask;
  logic [2*NUM_REQ-1:0] masked;

  assign dbl = {req, req};

  // Window covers ptr+1 .. ptr+NUM_REQ, i.e. every requester once, ptr itself last.
  generate
    for (genvar gi = 0; gi < 2*NUM_REQ; gi++) begin : g_mask
      assign mask[gi] = (gi > int'(ptr)) && (gi <= int'(ptr) + NUM_REQ);
    end
  endgenerate

  assign masked = dbl & mask;

  // Scan downwards so the lowest set bit in the window is the one that sticks.
  always_comb begin
    win    = '0;
    win_id = '0;
    for (int j = 2*NUM_REQ-1; j >= 0; j--) begin
      if (masked[j]) begin
        win              = '0;
        win[j % NUM_REQ] = 1'b1;
        win_id           = ID_W'(j % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner FSM for a shared tri-state bus: one-hot grants, one dead cycle
// between owners, and a bounded tenure whenever someone else is waiting.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int ID_W     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] drv_en,
  output logic               bus_busy,
  output logic [ID_W-1:0]    owner_id
);

  localparam int             HW        = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_t         state_reg, state_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [ID_W-1:0]    owner_id_reg, owner_id_next;
  logic [ID_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [HW-1:0]      hold_cnt_reg, hold_cnt_next;
  logic               busy_reg, busy_next;

  logic [NUM_REQ-1:0] pick_win;
  logic [ID_W-1:0]    pick_id;
  logic [NUM_REQ-1:0] others;
  logic               owner_req;
  logic               hold_ok;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req    (req),
    .ptr    (rr_ptr_reg),
    .win    (pick_win),
    .win_id (pick_id)
  );

  assign others    = req & ~gnt_reg;
  assign owner_req = req[owner_id_reg];
  assign hold_ok   = (hold_cnt_reg < HOLD_LAST) || (others == '0);

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    owner_id_next = owner_id_reg;
    rr_ptr_next   = rr_ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    busy_next     = busy_reg;
    case (state_reg)
      ST_IDLE, ST_TURN: begin
        if (|req) begin
          state_next    = ST_OWN;
          gnt_next      = pick_win;
          owner_id_next = pick_id;
          rr_ptr_next   = pick_id;
          hold_cnt_next = '0;
          busy_next     = 1'b1;
        end else begin
          state_next    = ST_IDLE;
          gnt_next      = '0;
          owner_id_next = '0;
          busy_next     = 1'b0;
        end
      end
      ST_OWN: begin
        if (owner_req && hold_ok) begin
          if (hold_cnt_reg < HOLD_LAST) hold_cnt_next = hold_cnt_reg + HW'(1);
        end else begin
          // Release and preemption both go through the all-off turnaround cycle.
          state_next    = ST_TURN;
          gnt_next      = '0;
          owner_id_next = '0;
          busy_next     = 1'b0;
        end
      end
      default: begin
        state_next    = ST_IDLE;
        gnt_next      = '0;
        owner_id_next = '0;
        busy_next     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      gnt_reg      <= '0;
      owner_id_reg <= '0;
      rr_ptr_reg   <= ID_W'(NUM_REQ - 1);
      hold_cnt_reg <= '0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      owner_id_reg <= owner_id_next;
      rr_ptr_reg   <= rr_ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      busy_reg     <= busy_next;
    end
  end

  assign gnt      = gnt_reg;
  assign drv_en   = gnt_reg;
  assign bus_busy = busy_reg;
  assign owner_id = owner_id_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, grant latency, release, round-robin
// preemption, lone-owner hold, async reset mid-tenure, and a random invariant soak.
module tb_bus_arbiter;

  localparam int N     = 4;
  localparam int MH    = 8;
  localparam int BOUND = (N-1)*(MH+1)+1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [N-1:0] drv_en;
  logic         bus_busy;
  logic [1:0]   owner_id;

  int passed = 0;
  int total  = 0;

  bus_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH), .ID_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .drv_en   (drv_en),
    .bus_busy (bus_busy),
    .owner_id (owner_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int           onehot_err;
  int           drv_err;
  int           gap_err;
  int           wait_err;
  int           wait_cnt [N];
  logic [N-1:0] prev_gnt;
  logic [N-1:0] exp_g;

  initial begin
    // 1: reset holds outputs off even with every request high
    req = 4'b1111;
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_drv", 32'(drv_en), 32'h0);
    chk("rst_busy", 32'(bus_busy), 32'h0);
    chk("rst_owner", 32'(owner_id), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("first_gnt", 32'(gnt), 32'h1);
    chk("first_owner", 32'(owner_id), 32'h0);
    req = 4'b0000;
    tick();
    chk("t1_turn", 32'(gnt), 32'h0);
    tick();
    chk("t1_idle", 32'(gnt), 32'h0);
    $display("step1 reset/first grant done");

    // 2: single requester, latency 1, release then turnaround then idle
    req = 4'b0100;
    tick();
    chk("t2_gnt", 32'(gnt), 32'h4);
    chk("t2_owner", 32'(owner_id), 32'h2);
    chk("t2_busy", 32'(bus_busy), 32'h1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t2_hold", 32'(gnt), 32'h4);
    end
    req = 4'b0000;
    tick();
    chk("t2_turn", 32'(gnt), 32'h0);
    chk("t2_turn_busy", 32'(bus_busy), 32'h0);
    tick();
    chk("t2_idle", 32'(gnt), 32'h0);
    chk("t2_idle_owner", 32'(owner_id), 32'h0);
    $display("step2 release/turnaround done");

    // 3: all requesting -> owners 0,1,2,3,0, 8 cycles each, one dead cycle between
    rst_n = 1'b0;
    req = 4'b1111;
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % N);
      for (int c = 0; c < MH; c++) begin
        tick();
        chk("t3_gnt", 32'(gnt), 32'(exp_g));
        chk("t3_owner", 32'(owner_id), 32'(k % N));
      end
      if (k < 4) begin
        tick();
        chk("t3_gap", 32'(gnt), 32'h0);
      end
      $display("step3 tenure owner=%0d", k % N);
    end

    // 4: lone requester is never preempted
    req = 4'b0010;
    tick();
    chk("t4_turn", 32'(gnt), 32'h0);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("t4_hold", 32'(gnt), 32'h2);
    end
    $display("step4 lone owner held 20 cycles");

    // 5: async reset while owner 3 is mid-tenure
    req = 4'b1000;
    tick();
    chk("t5_turn", 32'(gnt), 32'h0);
    tick();
    chk("t5_gnt3", 32'(gnt), 32'h8);
    for (int c = 0; c < 4; c++) tick();
    chk("t5_still3", 32'(gnt), 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_drv", 32'(drv_en), 32'h0);
    chk("t5_async_busy", 32'(bus_busy), 32'h0);
    chk("t5_async_owner", 32'(owner_id), 32'h0);
    req = 4'b1111;
    #1;
    rst_n = 1'b1;
    tick();
    chk("t5_restart", 32'(gnt), 32'h1);
    $display("step5 async reset mid-tenure done");

    // 6: random soak with invariant checks
    onehot_err = 0; drv_err = 0; gap_err = 0; wait_err = 0;
    prev_gnt = gnt;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      if (!$onehot0(gnt)) onehot_err++;
      if (drv_en !== gnt) drv_err++;
      if (prev_gnt != '0 && gnt != '0 && gnt != prev_gnt) gap_err++;
      for (int i = 0; i < N; i++) begin
        if (req[i] && !gnt[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > BOUND) wait_err++;
      end
      prev_gnt = gnt;
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) req[i] = ~req[i];
    end
    chk("t6_onehot", 32'(onehot_err), 32'h0);
    chk("t6_drv_eq_gnt", 32'(drv_err), 32'h0);
    chk("t6_zero_gap", 32'(gap_err), 32'h0);
    chk("t6_wait_bound", 32'(wait_err), 32'h0);
    $display("step6 random soak 4000 cycles done");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
